// File: rtl/rng_conditioner.sv
// Conditions the raw LHCA word stream: warm-up discard, repetition-count health test,
// XOR-folding into a small FIFO. Optional word counter enabled by RNG_COND_STATS_EN.
module rng_conditioner #(
    parameter int WIDTH     = 32,
    parameter int FOLD      = 4,
    parameter int DEPTH     = 8,
    parameter int WARMUP    = 16,
    parameter int REP_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [WIDTH-1:0]         raw_i,
    input  logic                     raw_valid_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         rnd_o,
    output logic                     rnd_valid_o,
    input  logic                     rnd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     health_fail_o,
    output logic                     overflow_o,
    output logic [15:0]              stat_words_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int WCW = $clog2(WARMUP + 1);
    localparam int FCW = $clog2(FOLD + 1);
    localparam int RCW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {ST_WARMUP, ST_COLLECT, ST_FAIL} state_t;

    state_t            r_state, w_state_next;
    logic [WCW-1:0]    r_warm_cnt;
    logic [FCW-1:0]    r_fold_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_prev;
    logic              r_prev_valid;
    logic [RCW-1:0]    r_rep_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [WIDTH-1:0]  r_head;
    logic              r_overflow;

    logic              w_accept, w_rep_trip, w_warm_done, w_fold_done;
    logic              w_push_req, w_push, w_pop, w_flush;
    logic [RCW-1:0]    w_rep_next;
    logic [WIDTH-1:0]  w_word;
    logic [AW-1:0]     w_rd_ptr_inc;

    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_accept     = raw_valid_i && en_i && (r_state != ST_FAIL);
        w_rep_next   = (r_prev_valid && (raw_i == r_prev)) ? RCW'(r_rep_cnt + 1'b1) : RCW'(1);
        w_rep_trip   = w_accept && (w_rep_next >= RCW'(REP_LIMIT));
        w_warm_done  = (r_warm_cnt == WCW'(WARMUP - 1));
        w_fold_done  = (r_fold_cnt == FCW'(FOLD - 1));
        w_word       = r_acc ^ raw_i;
        case (r_state)
            ST_WARMUP: begin
                if (w_rep_trip)
                    w_state_next = ST_FAIL;
                else if (w_accept && w_warm_done)
                    w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_rep_trip)
                    w_state_next = ST_FAIL;
                else
                    w_push_req = w_accept && w_fold_done;
            end
            default: ;
        endcase
        if (clear_i) begin
            w_state_next = ST_WARMUP;
            w_push_req   = 1'b0;
        end
        // A health trip or the FAIL state keeps the FIFO empty
        w_flush      = clear_i || w_rep_trip || (r_state == ST_FAIL);
        w_pop        = (r_level != '0) && rnd_ready_i && !w_flush;
        w_push       = w_push_req && ((r_level != LW'(DEPTH)) || w_pop);
        w_rd_ptr_inc = AW'(r_rd_ptr + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_WARMUP;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            r_warm_cnt   <= '0;
            r_fold_cnt   <= '0;
            r_acc        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_rep_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_head       <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= w_push_req && !w_push;
            if (w_accept) begin
                r_rep_cnt    <= w_rep_next;
                r_prev       <= raw_i;
                r_prev_valid <= 1'b1;
                if (r_state == ST_WARMUP)
                    r_warm_cnt <= w_warm_done ? '0 : WCW'(r_warm_cnt + 1'b1);
                if (r_state == ST_COLLECT) begin
                    if (w_fold_done || w_rep_trip) begin
                        r_acc      <= '0;
                        r_fold_cnt <= '0;
                    end else begin
                        r_acc      <= w_word;
                        r_fold_cnt <= FCW'(r_fold_cnt + 1'b1);
                    end
                end
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_head   <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
                if (w_pop)
                    r_rd_ptr <= w_rd_ptr_inc;
                r_level <= LW'(r_level + LW'(w_push) - LW'(w_pop));
                // Head takes the new word directly when it becomes the only entry
                if (w_push && ((r_level == '0) || ((r_level == LW'(1)) && w_pop)))
                    r_head <= w_word;
                else if (w_pop && (r_level > LW'(1)))
                    r_head <= r_mem[w_rd_ptr_inc];
            end
        end
    end

`ifdef RNG_COND_STATS_EN
    logic [15:0] r_stat_words;

    always_ff @(posedge clk) begin
        if (!rst)
            r_stat_words <= '0;
        else if (w_push)
            r_stat_words <= r_stat_words + 16'd1;
    end

    assign stat_words_o = r_stat_words;
`else
    assign stat_words_o = '0;
`endif

    assign rnd_o         = r_head;
    assign rnd_valid_o   = (r_level != '0);
    assign level_o       = r_level;
    assign health_fail_o = (r_state == ST_FAIL);
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_rng_conditioner.sv
// Directed bench for rng_conditioner with WIDTH=32, FOLD=4, DEPTH=8, WARMUP=16, REP_LIMIT=4.
module tb_rng_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] raw_i = '0;
    logic        raw_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        rnd_ready_i = 1'b0;
    logic [31:0] rnd_o;
    logic        rnd_valid_o;
    logic [3:0]  level_o;
    logic        health_fail_o;
    logic        overflow_o;
    logic [15:0] stat_words_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] seq = 32'h1000_0000;
    logic [31:0] t2_words [8];

`ifdef RNG_COND_STATS_EN
    localparam logic [15:0] EXP_STATS = 16'd8;
`else
    localparam logic [15:0] EXP_STATS = 16'd0;
`endif

    rng_conditioner #(
        .WIDTH(32), .FOLD(4), .DEPTH(8), .WARMUP(16), .REP_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .raw_i(raw_i), .raw_valid_i(raw_valid_i),
        .clear_i(clear_i), .rnd_o(rnd_o), .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i),
        .level_o(level_o), .health_fail_o(health_fail_o), .overflow_o(overflow_o),
        .stat_words_o(stat_words_o)
    );

    always #5 clk = ~clk;

    task automatic sample(input logic [31:0] d);
        raw_i       = d;
        raw_valid_i = 1'b1;
        en_i        = 1'b1;
        @(posedge clk);
        #1;
        raw_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        raw_valid_i = 1'b0;
        rnd_ready_i = 1'b0;
        clear_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic warmup();
        for (int i = 0; i < 16; i++) begin
            sample(seq);
            seq = seq + 32'd1;
        end
    endtask

    task automatic fold_word(output logic [31:0] w);
        w = '0;
        for (int i = 0; i < 4; i++) begin
            sample(seq);
            w = w ^ seq;
            seq = seq + 32'd1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rnd_o !== 32'd0) begin n_err++; $display("FAIL reset_rnd: got %h want 0", rnd_o); end
        n_cmp++; if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rnd_valid_o); end
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level_o); end
        n_cmp++; if (health_fail_o !== 1'b0) begin n_err++; $display("FAIL reset_health: got %b want 0", health_fail_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        n_cmp++; if (stat_words_o !== 16'd0) begin n_err++; $display("FAIL reset_stats: got %0d want 0", stat_words_o); end
        $display("test_reset done");
    endtask

    task automatic test_basic_fold();
        warmup();
        sample(32'h1); sample(32'h2); sample(32'h4);
        n_cmp++; if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t1_early_valid: got %b want 0", rnd_valid_o); end
        sample(32'h8);
        n_cmp++; if (rnd_valid_o !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b want 1", rnd_valid_o); end
        n_cmp++; if (rnd_o !== 32'h0000000F) begin n_err++; $display("FAIL t1_word: got %h want 0000000f", rnd_o); end
        n_cmp++; if (level_o !== 4'd1) begin n_err++; $display("FAIL t1_level: got %0d want 1", level_o); end
        rnd_ready_i = 1'b1;
        @(posedge clk); #1;
        rnd_ready_i = 1'b0;
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL t1_pop_level: got %0d want 0", level_o); end
        n_cmp++; if (rnd_o !== 32'h0000000F) begin n_err++; $display("FAIL t1_hold_word: got %h want 0000000f", rnd_o); end
        $display("test_basic_fold done");
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        do_reset();
        warmup();
        for (int k = 0; k < 8; k++) begin
            fold_word(w);
            t2_words[k] = w;
        end
        n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL t2_full_level: got %0d want 8", level_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL t2_no_ovf: got %b want 0", overflow_o); end
        fold_word(w);
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL t2_ovf: got %b want 1", overflow_o); end
        n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL t2_ovf_level: got %0d want 8", level_o); end
        @(posedge clk); #1;
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL t2_ovf_pulse: got %b want 0", overflow_o); end
        n_cmp++; if (stat_words_o !== EXP_STATS) begin n_err++; $display("FAIL t2_stats: got %0d want %0d", stat_words_o, EXP_STATS); end
        n_cmp++; if (rnd_o !== t2_words[0]) begin n_err++; $display("FAIL t2_head: got %h want %h", rnd_o, t2_words[0]); end
        $display("test_overflow done");
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w_new;
        logic [31:0] e;
        w_new = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rnd_ready_i = 1'b1;
            sample(seq);
            w_new = w_new ^ seq;
            seq = seq + 32'd1;
        end
        rnd_ready_i = 1'b0;
        n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL t4_level: got %0d want 8", level_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL t4_ovf: got %b want 0", overflow_o); end
        rnd_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = (i < 7) ? t2_words[i + 1] : w_new;
            n_cmp++; if (rnd_o !== e) begin n_err++; $display("FAIL t4_drain%0d: got %h want %h", i, rnd_o, e); end
            @(posedge clk); #1;
        end
        rnd_ready_i = 1'b0;
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL t4_empty: got %0d want 0", level_o); end
        $display("test_full_push_pop done");
    endtask

    task automatic test_health();
        logic [31:0] w;
        do_reset();
        warmup();
        for (int k = 0; k < 3; k++) fold_word(w);
        sample(32'hDEADBEEF); sample(32'hDEADBEEF); sample(32'hDEADBEEF);
        n_cmp++; if (health_fail_o !== 1'b0) begin n_err++; $display("FAIL t3_early_fail: got %b want 0", health_fail_o); end
        n_cmp++; if (level_o !== 4'd3) begin n_err++; $display("FAIL t3_level3: got %0d want 3", level_o); end
        sample(32'hDEADBEEF);
        n_cmp++; if (health_fail_o !== 1'b1) begin n_err++; $display("FAIL t3_fail: got %b want 1", health_fail_o); end
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL t3_flush_level: got %0d want 0", level_o); end
        n_cmp++; if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t3_flush_valid: got %b want 0", rnd_valid_o); end
        n_cmp++; if (rnd_o !== 32'd0) begin n_err++; $display("FAIL t3_flush_rnd: got %h want 0", rnd_o); end
        for (int k = 0; k < 2; k++) fold_word(w);
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL t3_ignored: got %0d want 0", level_o); end
        n_cmp++; if (health_fail_o !== 1'b1) begin n_err++; $display("FAIL t3_sticky: got %b want 1", health_fail_o); end
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        n_cmp++; if (health_fail_o !== 1'b0) begin n_err++; $display("FAIL t3_clear: got %b want 0", health_fail_o); end
        warmup();
        w = '0;
        for (int i = 0; i < 3; i++) begin
            sample(seq); w = w ^ seq; seq = seq + 32'd1;
        end
        n_cmp++; if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t3_rewarm_valid: got %b want 0", rnd_valid_o); end
        sample(seq); w = w ^ seq; seq = seq + 32'd1;
        n_cmp++; if (rnd_o !== w || rnd_valid_o !== 1'b1) begin n_err++; $display("FAIL t3_rewarm_word: got %h/%b want %h/1", rnd_o, rnd_valid_o, w); end
        $display("test_health done");
    endtask

    task automatic test_enable_hold();
        logic [31:0] w;
        do_reset();
        warmup();
        w = 32'h0000_0013 ^ 32'h0000_0500;
        sample(32'h0000_0013); sample(32'h0000_0500);
        en_i = 1'b0;
        raw_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            raw_i = 32'h7700_0000 + 32'(i);
            @(posedge clk); #1;
        end
        raw_valid_i = 1'b0;
        n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL t5_disabled: got %0d want 0", level_o); end
        sample(32'h0002_0000); sample(32'h8000_0000);
        w = w ^ 32'h0002_0000 ^ 32'h8000_0000;
        n_cmp++; if (level_o !== 4'd1) begin n_err++; $display("FAIL t5_level: got %0d want 1", level_o); end
        n_cmp++; if (rnd_o !== w) begin n_err++; $display("FAIL t5_word: got %h want %h", rnd_o, w); end
        $display("test_enable_hold done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset();
        warmup();
        for (int k = 0; k < 5; k++) fold_word(w);
        sample(seq); seq = seq + 32'd1;
        sample(seq); seq = seq + 32'd1;
        n_cmp++; if (level_o !== 4'd5) begin n_err++; $display("FAIL t6_pre_level: got %0d want 5", level_o); end
        rst = 1'b0;
        raw_i = seq; raw_valid_i = 1'b1; en_i = 1'b1; rnd_ready_i = 1'b1; clear_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; raw_valid_i = 1'b0; rnd_ready_i = 1'b0; clear_i = 1'b0;
        seq = seq + 32'd1;
        n_cmp++; if (level_o !== 4'd0 || rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t6_rst_level: got %0d/%b want 0/0", level_o, rnd_valid_o); end
        n_cmp++; if (rnd_o !== 32'd0) begin n_err++; $display("FAIL t6_rst_rnd: got %h want 0", rnd_o); end
        n_cmp++; if (health_fail_o !== 1'b0 || overflow_o !== 1'b0) begin n_err++; $display("FAIL t6_rst_flags: got %b%b want 00", health_fail_o, overflow_o); end
        n_cmp++; if (stat_words_o !== 16'd0) begin n_err++; $display("FAIL t6_rst_stats: got %0d want 0", stat_words_o); end
        warmup();
        w = '0;
        for (int i = 0; i < 3; i++) begin
            sample(seq); w = w ^ seq; seq = seq + 32'd1;
        end
        n_cmp++; if (rnd_valid_o !== 1'b0) begin n_err++; $display("FAIL t6_early_valid: got %b want 0", rnd_valid_o); end
        sample(seq); w = w ^ seq; seq = seq + 32'd1;
        n_cmp++; if (rnd_o !== w || level_o !== 4'd1) begin n_err++; $display("FAIL t6_word: got %h/%0d want %h/1", rnd_o, level_o, w); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic_fold();
        test_overflow();
        test_full_push_pop();
        test_health();
        test_enable_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
